// File: rtl/fp_round_pkg.sv
// rtl/fp_round_pkg.sv - rounding mode encodings, stage-1 payload and overflow policy
package fp_round_pkg;

    typedef enum logic [1:0] {
        RM_NEAR = 2'b00,
        RM_ZERO = 2'b01,
        RM_PINF = 2'b10,
        RM_NINF = 2'b11
    } rmode_e;

    // Width-independent part of the stage-1 payload; exponent and fraction
    // are sized by the pipe parameters and held alongside it.
    typedef struct packed {
        logic   sign;
        logic   carry;
        logic   inexact;
        logic   exp_sat;
        rmode_e rmode;
    } s1_ctrl_t;

    // On overflow a mode that rounds away from zero for this sign yields
    // infinity; every other case saturates to max-finite.
    function automatic logic ovf_to_inf(input logic sign, input rmode_e rmode);
        logic to_inf;
        to_inf = 1'b0;
        case (rmode)
            RM_NEAR: to_inf = 1'b1;
            RM_ZERO: to_inf = 1'b0;
            RM_PINF: to_inf = ~sign;
            RM_NINF: to_inf = sign;
            default: to_inf = 1'b1;
        endcase
        return to_inf;
    endfunction

endpackage

// File: rtl/fp_round_decide.sv
// rtl/fp_round_decide.sv - round-increment decision from sign, lsb, guard, sticky and mode
module fp_round_decide
    import fp_round_pkg::*;
(
    input  logic   sign,
    input  logic   lsb,
    input  logic   guard,
    input  logic   sticky,
    input  rmode_e rmode,
    output logic   rnd
);

    always_comb begin
        rnd = 1'b0;
        case (rmode)
            RM_NEAR: rnd = guard & (lsb | sticky);
            RM_ZERO: rnd = 1'b0;
            RM_PINF: rnd = ~sign & (guard | sticky);
            RM_NINF: rnd = sign & (guard | sticky);
            default: rnd = 1'b0;
        endcase
    end

endmodule

// File: rtl/fp_round_pipe.sv
// rtl/fp_round_pipe.sv - two-stage IEEE-754 rounding pipe with carry-out and overflow saturation
module fp_round_pipe
    import fp_round_pkg::*;
#(
    parameter int MANT_W = 23,
    parameter int EXP_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic [MANT_W:0]   in_mant,
    input  logic              in_guard,
    input  logic              in_sticky,
    input  logic [1:0]        in_rmode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sign,
    output logic [EXP_W-1:0]  out_exp,
    output logic [MANT_W-1:0] out_frac,
    output logic              out_inexact,
    output logic              out_overflow
);

    localparam logic [EXP_W-1:0]  EXP_ONES  = '1;
    localparam logic [EXP_W-1:0]  EXP_MAXF  = EXP_ONES - 1'b1;
    localparam logic [MANT_W-1:0] FRAC_ONES = '1;

    logic              s1_valid;
    logic              s2_valid;
    logic              en1;
    logic              en2;
    s1_ctrl_t          s1_ctrl;
    logic [EXP_W-1:0]  s1_exp;
    logic [MANT_W-1:0] s1_frac;

    logic              rnd;
    logic [MANT_W+1:0] sum_w;
    logic              unused_hidden;

    logic [EXP_W:0]    exp_n;
    logic              ovf;
    logic              to_inf;
    logic [EXP_W-1:0]  s2_exp_d;
    logic [MANT_W-1:0] s2_frac_d;

    // Downstream readiness ripples straight back to in_ready so a full,
    // draining pipe still accepts a beat every cycle.
    assign en2       = ~s2_valid | out_ready;
    assign en1       = ~s1_valid | en2;
    assign in_ready  = en1;
    assign out_valid = s2_valid;

    fp_round_decide u_decide (
        .sign   (in_sign),
        .lsb    (in_mant[0]),
        .guard  (in_guard),
        .sticky (in_sticky),
        .rmode  (rmode_e'(in_rmode)),
        .rnd    (rnd)
    );

    assign sum_w         = {1'b0, in_mant} + {{(MANT_W + 1){1'b0}}, rnd};
    assign unused_hidden = sum_w[MANT_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_ctrl  <= '0;
            s1_exp   <= '0;
            s1_frac  <= '0;
        end else if (en1) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_ctrl.sign    <= in_sign;
                s1_ctrl.carry   <= sum_w[MANT_W+1];
                s1_ctrl.inexact <= in_guard | in_sticky;
                s1_ctrl.exp_sat <= (in_exp == EXP_ONES);
                s1_ctrl.rmode   <= rmode_e'(in_rmode);
                s1_exp          <= in_exp;
                s1_frac         <= sum_w[MANT_W-1:0];
            end
        end
    end

    // A carry out of the significand means 10.0...0, renormalised to a
    // zero fraction with the exponent bumped by one.
    assign exp_n  = {1'b0, s1_exp} + {{EXP_W{1'b0}}, s1_ctrl.carry};
    assign ovf    = s1_ctrl.exp_sat | (exp_n >= {1'b0, EXP_ONES});
    assign to_inf = ovf_to_inf(s1_ctrl.sign, s1_ctrl.rmode);

    always_comb begin
        s2_exp_d  = exp_n[EXP_W-1:0];
        s2_frac_d = s1_ctrl.carry ? '0 : s1_frac;
        if (ovf) begin
            s2_exp_d  = to_inf ? EXP_ONES : EXP_MAXF;
            s2_frac_d = to_inf ? '0 : FRAC_ONES;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid     <= 1'b0;
            out_sign     <= 1'b0;
            out_exp      <= '0;
            out_frac     <= '0;
            out_inexact  <= 1'b0;
            out_overflow <= 1'b0;
        end else if (en2) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_sign     <= s1_ctrl.sign;
                out_exp      <= s2_exp_d;
                out_frac     <= s2_frac_d;
                out_inexact  <= s1_ctrl.inexact | ovf;
                out_overflow <= ovf;
            end
        end
    end

endmodule

// File: doc/fp_round_pipe.md
# fp_round_pipe

Parametrised, pipelined IEEE-754 rounding stage that succeeds the single-precision multiplier rounding logic. It accepts a normalised significand with guard/sticky bits, sign, biased exponent and rounding mode. It applies the mode's increment decision, propagates mantissa carry into the exponent, and resolves exponent overflow to infinity or max-finite per mode. It sits between the normaliser and the result packer of any FPU datapath (mul/add/div) behind a valid/ready handshake.

## Interface
- MANT_W, 23, fraction width (hidden bit excluded)
- EXP_W, 8, biased exponent width
- clk  in  1  clock; all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat this cycle
- in_sign  in  1  result sign
- in_exp  in  EXP_W  biased exponent after normalisation; all-ones = already overflowed
- in_mant  in  MANT_W+1  hidden bit + fraction (hidden bit = 1)
- in_guard  in  1  first bit below LSB
- in_sticky  in  1  OR of all bits below guard
- in_rmode  in  2  00 nearest-even, 01 toward zero, 10 toward +inf, 11 toward -inf
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts
- out_sign  out  1  result sign
- out_exp  out  EXP_W  rounded biased exponent
- out_frac  out  MANT_W  rounded fraction
- out_inexact  out  1  guard | sticky | overflow
- out_overflow  out  1  result exponent overflowed

## Operation
- Stage 1 (decide/add): rnd = nearest: G&(L|T), L = in_mant[0]; zero: 0; +inf: !sign&(G|T); -inf: sign&(G|T). {carry, sum} = in_mant + rnd, sum MANT_W+1 bits. Register sign, exp, carry, sum[MANT_W-1:0], inexact = G|T, rmode.
- Stage 2 (exp adjust/saturate): exp_n = exp + carry, computed EXP_W+1 bits wide. If carry, fraction = 0 (significand 10.0…0 renormalised); otherwise the fraction is sum[MANT_W-1:0].
- Overflow when exp_n >= 2^EXP_W-1, or input exp was all-ones. Result on overflow: nearest → ±inf (exp all-ones, frac 0). Zero → ±max-finite (exp all-ones-1, frac all-ones). +inf → +inf if positive, −max-finite if negative. -inf → −inf if negative, +max-finite if positive. out_overflow=1; out_inexact=1.
- Overflow on an already-overflowed input uses the same mode table regardless of G/T.
- Sign is passed through unchanged in all cases.

## Timing
- Reset: s1_valid=0, s2_valid=0. Hence out_valid=0, in_ready=1. All data outputs reset to 0.
- Load enables: en2 = !s2_valid | out_ready; en1 = !s1_valid | en2; in_ready = en1. This is a combinational path from out_ready to in_ready.
- Input transfer on in_valid & in_ready. Output transfer on out_valid & out_ready.
- Latency: 2 cycles from input transfer to out_valid with no stall. Throughput: 1 beat/cycle.
- Stall: with out_ready=0, output data and out_valid hold stable. Stage 1 still fills if empty. in_ready falls only when both stages are full.
- Handshake: out_valid never drops without a transfer. Beats are never dropped or reordered.
- rst during activity: both stages are flushed on the next edge, and in-flight beats are discarded.
- in_rmode is sampled per beat with the input, so mode changes between beats are legal.

## Structure
- Package fp_round_pkg holds the rmode encodings (RM_NEAR=2'b00, RM_ZERO=2'b01, RM_PINF=2'b10, RM_NINF=2'b11) and the stage-1 payload struct typedef.
- Sub-module fp_round_decide: combinational rnd from {sign, L, G, T, rmode}. It is reused by the adder and divider rounding paths.
- fp_round_pipe holds the two pipeline registers, the handshake logic and the stage-2 saturation.

## Test plan
All cases use MANT_W=23, EXP_W=8.
- Nearest-even ties: mant 0x800001, G=1, T=0 → frac 0x000002. Mant 0x800002, G=1, T=0 → frac 0x000002, inexact=1.
- Directed modes at exp 0x7F, mant 0x800000, G=0, T=1: +inf with sign=0 → frac 0x000001; +inf with sign=1 → frac 0x000000; -inf with sign=1 → frac 0x000001; zero → frac 0x000000. All four give inexact=1.
- Mantissa carry: exp 0x7F, mant 0xFFFFFF, G=1, T=1, nearest → exp 0x80, frac 0, overflow=0, inexact=1.
- Exponent overflow: exp 0xFE, mant 0xFFFFFF, G=1. Nearest → exp 0xFF frac 0, overflow=1. Zero → exp 0xFE frac 0x7FFFFF. -inf with sign=0 → exp 0xFE frac 0x7FFFFF.
- Backpressure: 6 back-to-back beats with out_ready=0 for cycles 2–5. in_ready goes low after 2 beats are held; all 6 beats emerge in order with none lost; out data is stable while stalled.
- Reset mid-stream: assert rst for 1 cycle with both stages valid → next cycle out_valid=0, in_ready=1. A beat sent after reset appears 2 cycles later.
